rc4_prga_core: RTL and testbench

Parametrised RC4 PRGA decrypt engine for the key-search datapath. It runs after key scheduling has filled the 256-byte S RAM. It walks MSG_LEN ciphertext bytes from ROM, generates the keystream, swaps S, XORs, and writes each plaintext byte to the decode RAM. Each byte is checked against a configurable character window, and the result is reported as success, failure or aborted.

---
 rtl/rc4_pkg.sv | 35 +++
 rtl/rc4_lat_wait.sv | 41 ++++
 rtl/rc4_prga_core.sv | 266 ++++++++++++++++++++++++++
 tb/tb_rc4_prga_core.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA decrypt engine.
package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SET_I,
        ST_WAIT_SI,
        ST_CALC_J,
        ST_WAIT_SJ,
        ST_WR_J,
        ST_WR_I,
        ST_RD_F,
        ST_WAIT_F,
        ST_XOR,
        ST_CHECK,
        ST_PASS,
        ST_FAIL,
        ST_ABORT
    } rc4_state_e;

    localparam logic [7:0] ASCII_SPACE = 8'd32;
    localparam logic [7:0] DEF_CHAR_LO = 8'd97;
    localparam logic [7:0] DEF_CHAR_HI = 8'd122;

    // True when a plaintext byte lies inside the accepted character window.
    function automatic logic char_ok(
        input logic [7:0] b,
        input logic [7:0] lo,
        input logic [7:0] hi,
        input logic       allow_space
    );
        return ((b >= lo) && (b <= hi)) || (allow_space && (b == ASCII_SPACE));
    endfunction

endpackage

// File: rtl/rc4_lat_wait.sv
// Loadable down-counter that times the fixed read latency of S RAM / ROM.
module rc4_lat_wait #(
    parameter int unsigned RAM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam int unsigned CW = (RAM_LAT > 2) ? $clog2(RAM_LAT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    // done rises in the last wait cycle so the FSM leaves after exactly RAM_LAT cycles
    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (load) begin
            cnt_d  = CW'(RAM_LAT - 1);
            done_d = (RAM_LAT == 32'd1);
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CW'(1);
            done_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/rc4_prga_core.sv
// RC4 keystream generator and decryptor: walks the ciphertext ROM, swaps S,
// writes plaintext to the decode RAM and classifies the run.
module rc4_prga_core
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN     = 32,
    parameter int unsigned MSG_AW      = $clog2(MSG_LEN),
    parameter int unsigned RAM_LAT     = 2,
    parameter logic [7:0]  CHAR_LO     = DEF_CHAR_LO,
    parameter logic [7:0]  CHAR_HI     = DEF_CHAR_HI,
    parameter bit          ALLOW_SPACE = 1'b1,
    parameter bit          CHECK_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [7:0]        s_q,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] rom_addr,
    output logic [MSG_AW-1:0] msg_addr,
    output logic [7:0]        msg_data,
    output logic              msg_wren,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic              failure,
    output logic              aborted,
    output logic [MSG_AW:0]   bytes_done
);

    localparam int unsigned BW = MSG_AW + 1;

    rc4_state_e        state_q, state_d;
    logic [7:0]        i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [MSG_AW-1:0] k_q, k_d;
    logic [7:0]        s_addr_q, s_addr_d, s_data_q, s_data_d;
    logic              s_wren_q, s_wren_d;
    logic [MSG_AW-1:0] rom_addr_q, rom_addr_d, msg_addr_q, msg_addr_d;
    logic [7:0]        msg_data_q, msg_data_d;
    logic              msg_wren_q, msg_wren_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              success_q, success_d, failure_q, failure_d, aborted_q, aborted_d;
    logic [BW-1:0]     bytes_done_q, bytes_done_d;
    logic              stop_pend_q, stop_pend_d;
    logic              wait_load_c, wait_done, byte_bad_c;

    rc4_lat_wait #(.RAM_LAT(RAM_LAT)) u_lat_wait (
        .clk  (clk),
        .reset(reset),
        .load (wait_load_c),
        .done (wait_done)
    );

    assign byte_bad_c = CHECK_EN && !char_ok(msg_data_q, CHAR_LO, CHAR_HI, ALLOW_SPACE);

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        k_d          = k_q;
        si_d         = si_q;
        sj_d         = sj_q;
        s_addr_d     = s_addr_q;
        s_data_d     = s_data_q;
        s_wren_d     = s_wren_q;
        rom_addr_d   = rom_addr_q;
        msg_addr_d   = msg_addr_q;
        msg_data_d   = msg_data_q;
        msg_wren_d   = msg_wren_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        success_d    = success_q;
        failure_d    = failure_q;
        aborted_d    = aborted_q;
        bytes_done_d = bytes_done_q;
        stop_pend_d  = stop_pend_q;
        wait_load_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    i_d          = 8'd0;
                    j_d          = 8'd0;
                    k_d          = '0;
                    bytes_done_d = '0;
                    success_d    = 1'b0;
                    failure_d    = 1'b0;
                    aborted_d    = 1'b0;
                    stop_pend_d  = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_SET_I;
                end
            end
            ST_SET_I: begin
                if (stop) begin
                    state_d = ST_ABORT;
                end else begin
                    i_d         = i_q + 8'd1;
                    s_addr_d    = i_q + 8'd1;
                    wait_load_c = 1'b1;
                    state_d     = ST_WAIT_SI;
                end
            end
            ST_WAIT_SI: begin
                if (stop)           state_d = ST_ABORT;
                else if (wait_done) state_d = ST_CALC_J;
            end
            ST_CALC_J: begin
                if (stop) begin
                    state_d = ST_ABORT;
                end else begin
                    si_d        = s_q;
                    j_d         = j_q + s_q;
                    s_addr_d    = j_q + s_q;
                    wait_load_c = 1'b1;
                    state_d     = ST_WAIT_SJ;
                end
            end
            ST_WAIT_SJ: begin
                if (stop)           state_d = ST_ABORT;
                else if (wait_done) state_d = ST_WR_J;
            end
            // The swap is never split: a stop seen here is remembered for RD_F.
            ST_WR_J: begin
                sj_d        = s_q;
                s_data_d    = si_q;
                s_wren_d    = 1'b1;
                stop_pend_d = stop;
                state_d     = ST_WR_I;
            end
            ST_WR_I: begin
                s_addr_d    = i_q;
                s_data_d    = sj_q;
                stop_pend_d = stop_pend_q | stop;
                state_d     = ST_RD_F;
            end
            ST_RD_F: begin
                s_wren_d    = 1'b0;
                stop_pend_d = 1'b0;
                if (stop || stop_pend_q) begin
                    state_d = ST_ABORT;
                end else begin
                    s_addr_d    = si_q + sj_q;
                    rom_addr_d  = k_q;
                    wait_load_c = 1'b1;
                    state_d     = ST_WAIT_F;
                end
            end
            ST_WAIT_F: begin
                if (stop)           state_d = ST_ABORT;
                else if (wait_done) state_d = ST_XOR;
            end
            ST_XOR: begin
                if (stop) begin
                    state_d = ST_ABORT;
                end else begin
                    msg_data_d   = s_q ^ rom_q;
                    msg_addr_d   = k_q;
                    msg_wren_d   = 1'b1;
                    bytes_done_d = bytes_done_q + BW'(1);
                    state_d      = ST_CHECK;
                end
            end
            // A failing byte is already decided, so it outranks a concurrent stop.
            ST_CHECK: begin
                msg_wren_d = 1'b0;
                if (byte_bad_c) begin
                    state_d = ST_FAIL;
                end else if (stop) begin
                    state_d = ST_ABORT;
                end else if (k_q == MSG_AW'(MSG_LEN - 1)) begin
                    state_d = ST_PASS;
                end else begin
                    k_d     = k_q + MSG_AW'(1);
                    state_d = ST_SET_I;
                end
            end
            ST_PASS: begin
                success_d = 1'b1;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            ST_FAIL: begin
                failure_d = 1'b1;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            ST_ABORT: begin
                s_wren_d   = 1'b0;
                msg_wren_d = 1'b0;
                aborted_d  = 1'b1;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            i_q          <= 8'd0;
            j_q          <= 8'd0;
            k_q          <= '0;
            si_q         <= 8'd0;
            sj_q         <= 8'd0;
            s_addr_q     <= 8'd0;
            s_data_q     <= 8'd0;
            s_wren_q     <= 1'b0;
            rom_addr_q   <= '0;
            msg_addr_q   <= '0;
            msg_data_q   <= 8'd0;
            msg_wren_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            success_q    <= 1'b0;
            failure_q    <= 1'b0;
            aborted_q    <= 1'b0;
            bytes_done_q <= '0;
            stop_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            k_q          <= k_d;
            si_q         <= si_d;
            sj_q         <= sj_d;
            s_addr_q     <= s_addr_d;
            s_data_q     <= s_data_d;
            s_wren_q     <= s_wren_d;
            rom_addr_q   <= rom_addr_d;
            msg_addr_q   <= msg_addr_d;
            msg_data_q   <= msg_data_d;
            msg_wren_q   <= msg_wren_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            success_q    <= success_d;
            failure_q    <= failure_d;
            aborted_q    <= aborted_d;
            bytes_done_q <= bytes_done_d;
            stop_pend_q  <= stop_pend_d;
        end
    end

    assign s_addr     = s_addr_q;
    assign s_data     = s_data_q;
    assign s_wren     = s_wren_q;
    assign rom_addr   = rom_addr_q;
    assign msg_addr   = msg_addr_q;
    assign msg_data   = msg_data_q;
    assign msg_wren   = msg_wren_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign success    = success_q;
    assign failure    = failure_q;
    assign aborted    = aborted_q;
    assign bytes_done = bytes_done_q;

endmodule

// File: tb/tb_rc4_prga_core.sv
// Scoreboard bench for rc4_prga_core: a 32-byte RAM_LAT=2 instance and an
// 8-byte RAM_LAT=1 unchecked instance share one S RAM / ROM model.
module tb_rc4_prga_core;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0, stop = 1'b0;
    logic sel = 1'b0, load_s = 1'b0;

    logic [7:0] s_q0, s_addr0, s_data0, rom_q0, msg_data0;
    logic [4:0] rom_addr0, msg_addr0;
    logic       s_wren0, msg_wren0, busy0, done0, success0, failure0, aborted0;
    logic [5:0] bytes_done0;

    logic [7:0] s_q1, s_addr1, s_data1, rom_q1, msg_data1;
    logic [2:0] rom_addr1, msg_addr1;
    logic       s_wren1, msg_wren1, busy1, done1, success1, failure1, aborted1;
    logic [3:0] bytes_done1;

    always #5 clk = ~clk;

    rc4_prga_core #(.MSG_LEN(32), .RAM_LAT(2)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .stop(stop),
        .s_q(s_q0), .s_addr(s_addr0), .s_data(s_data0), .s_wren(s_wren0),
        .rom_q(rom_q0), .rom_addr(rom_addr0),
        .msg_addr(msg_addr0), .msg_data(msg_data0), .msg_wren(msg_wren0),
        .busy(busy0), .done(done0), .success(success0), .failure(failure0),
        .aborted(aborted0), .bytes_done(bytes_done0)
    );

    rc4_prga_core #(.MSG_LEN(8), .RAM_LAT(1), .CHECK_EN(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .stop(stop),
        .s_q(s_q1), .s_addr(s_addr1), .s_data(s_data1), .s_wren(s_wren1),
        .rom_q(rom_q1), .rom_addr(rom_addr1),
        .msg_addr(msg_addr1), .msg_data(msg_data1), .msg_wren(msg_wren1),
        .busy(busy1), .done(done1), .success(success1), .failure(failure1),
        .aborted(aborted1), .bytes_done(bytes_done1)
    );

    logic [7:0] m_saddr, m_sdata, m_raddr, m_maddr, m_mdata;
    logic       m_swren, m_wren, m_done;
    assign m_saddr = sel ? s_addr1 : s_addr0;
    assign m_sdata = sel ? s_data1 : s_data0;
    assign m_swren = sel ? s_wren1 : s_wren0;
    assign m_raddr = sel ? 8'(rom_addr1) : 8'(rom_addr0);
    assign m_maddr = sel ? 8'(msg_addr1) : 8'(msg_addr0);
    assign m_mdata = sel ? msg_data1 : msg_data0;
    assign m_wren  = sel ? msg_wren1 : msg_wren0;
    assign m_done  = sel ? done1 : done0;

    // Memory model: one registered stage per cycle of latency
    logic [7:0] smem [256];
    logic [7:0] s_init [256];
    logic [7:0] s_snap [256];
    logic [7:0] rom_img [256];
    logic [7:0] pt [256];
    logic [7:0] sp0, sp1, rp0, rp1;

    always @(posedge clk) begin
        if (load_s) begin
            for (int a = 0; a < 256; a++) smem[a] <= s_init[a];
        end else if (m_swren) begin
            smem[m_saddr] <= m_sdata;
        end
        sp0 <= smem[m_saddr];
        sp1 <= sp0;
        rp0 <= rom_img[m_raddr];
        rp1 <= rp0;
    end
    assign s_q0 = sp1;
    assign rom_q0 = rp1;
    assign s_q1 = sp0;
    assign rom_q1 = rp0;

    int n_mwr = 0, n_swr = 0, n_done = 0;
    always @(negedge clk) begin
        if (m_wren) n_mwr <= n_mwr + 1;
        if (m_swren) n_swr <= n_swr + 1;
        if (m_done) n_done <= n_done + 1;
    end

    exp_t sb_q[$];
    int n_chk = 0, n_fail = 0;
    logic [7:0] s1_first;
    int done_at, first_wr, mwr0, swr0, dn0;

    task automatic set_identity();
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    endtask

    task automatic set_perm();
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a * 5 + 3);
    endtask

    task automatic set_text();
        for (int k = 0; k < 256; k++) pt[k] = (k % 6 == 5) ? 8'd32 : 8'(97 + (k * 7) % 26);
    endtask

    // Golden RC4 PRGA: fills the ROM, queues the first nexp writes, snapshots S after snap bytes
    task automatic build(input int len, input int nexp, input int snap);
        logic [7:0] s [256];
        logic [7:0] i, j, t, fa;
        exp_t e;
        for (int a = 0; a < 256; a++) s[a] = s_init[a];
        i = 8'd0;
        j = 8'd0;
        for (int k = 0; k < len; k++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i];
            s[i] = s[j];
            s[j] = t;
            fa = s[i] + s[j];
            rom_img[k] = pt[k] ^ s[fa];
            if (k < nexp) begin
                e.addr = 8'(k);
                e.data = pt[k];
                sb_q.push_back(e);
            end
            if (k + 1 == snap) for (int a = 0; a < 256; a++) s_snap[a] = s[a];
        end
    endtask

    task automatic load_ram();
        @(negedge clk);
        load_s = 1'b1;
        @(negedge clk);
        load_s = 1'b0;
    endtask

    task automatic do_start(input logic which);
        mwr0 = n_mwr;
        swr0 = n_swr;
        dn0 = n_done;
        @(negedge clk);
        if (which) start1 = 1'b1;
        else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Runs from the cycle after start accept (cycle 1), popping the scoreboard on each write
    task automatic watch(input int budget, input int stop_at);
        int n;
        bit got;
        exp_t e;
        n = 1;
        got = 1'b0;
        done_at = -1;
        first_wr = -1;
        while (!got && n < budget) begin
            @(negedge clk);
            n++;
            if (stop_at > 0 && n >= stop_at) stop = 1'b1;
            if (m_wren) begin
                if (first_wr < 0) begin
                    first_wr = n;
                    s1_first = smem[1];
                end
                n_chk++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: write addr %0d data %h at cycle %0d, none expected",
                             m_maddr, m_mdata, n);
                end else begin
                    e = sb_q.pop_front();
                    if ({m_maddr, m_mdata} !== e) begin
                        n_fail++;
                        $display("FAIL sb_msg: got addr %0d data %h, expected addr %0d data %h",
                                 m_maddr, m_mdata, e.addr, e.data);
                    end
                end
            end
            if (m_done) begin
                got = 1'b1;
                done_at = n;
            end
        end
        stop = 1'b0;
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d expected writes never seen", sb_q.size());
        end
        sb_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy0, done0, success0, failure0, aborted0, s_wren0, msg_wren0} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_flags0: got %b required 0000000",
                     {busy0, done0, success0, failure0, aborted0, s_wren0, msg_wren0});
        end
        n_chk++;
        if (bytes_done0 !== 6'd0 || s_addr0 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_regs0: bytes_done %0d s_addr %0d required 0 0", bytes_done0, s_addr0);
        end
        n_chk++;
        if ({busy1, done1, success1, s_wren1, msg_wren1} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_flags1: got %b required 00000",
                     {busy1, done1, success1, s_wren1, msg_wren1});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        stop = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        start0 = 1'b0;
        n_chk++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_over_start: busy %b required 0", busy0);
        end
    endtask

    task automatic test_identity();
        sel = 1'b0;
        set_identity();
        set_text();
        build(32, 32, 0);
        load_ram();
        do_start(1'b0);
        watch(700, 0);
        n_chk++;
        if (first_wr != 13) begin
            n_fail++;
            $display("FAIL first_write_cycle: got %0d required 13", first_wr);
        end
        n_chk++;
        if (s1_first !== 8'd1) begin
            n_fail++;
            $display("FAIL ident_s1: S[1] %0d required 1", s1_first);
        end
        n_chk++;
        if (success0 !== 1'b1) begin
            n_fail++;
            $display("FAIL ident_success: got %b required 1", success0);
        end
    endtask

    task automatic test_golden_pass();
        sel = 1'b0;
        set_perm();
        set_text();
        build(32, 32, 0);
        load_ram();
        do_start(1'b0);
        watch(700, 0);
        n_chk++;
        if (done_at != 418) begin
            n_fail++;
            $display("FAIL pass_done_cycle: got %0d required 418", done_at);
        end
        n_chk++;
        if ({success0, failure0, aborted0, busy0} !== 4'b1000) begin
            n_fail++;
            $display("FAIL pass_flags: s/f/a/busy %b required 1000", {success0, failure0, aborted0, busy0});
        end
        n_chk++;
        if (n_mwr - mwr0 != 32 || n_done - dn0 != 1) begin
            n_fail++;
            $display("FAIL pass_counts: msg_wren %0d done %0d required 32 1", n_mwr - mwr0, n_done - dn0);
        end
        n_chk++;
        if (bytes_done0 !== 6'd32) begin
            n_fail++;
            $display("FAIL pass_bytes_done: got %0d required 32", bytes_done0);
        end
    endtask

    task automatic test_fail();
        sel = 1'b0;
        set_perm();
        set_text();
        pt[5] = 8'h41;
        build(32, 6, 0);
        load_ram();
        do_start(1'b0);
        watch(700, 0);
        n_chk++;
        if ({success0, failure0, aborted0} !== 3'b010) begin
            n_fail++;
            $display("FAIL fail_flags: s/f/a %b required 010", {success0, failure0, aborted0});
        end
        n_chk++;
        if (done_at != 80) begin
            n_fail++;
            $display("FAIL fail_done_cycle: got %0d required 80", done_at);
        end
        n_chk++;
        if (n_mwr - mwr0 != 6 || bytes_done0 !== 6'd6) begin
            n_fail++;
            $display("FAIL fail_bytes: msg_wren %0d bytes_done %0d required 6 6", n_mwr - mwr0, bytes_done0);
        end
        n_chk++;
        if (n_swr - swr0 != 12) begin
            n_fail++;
            $display("FAIL fail_s_writes: got %0d required 12", n_swr - swr0);
        end
    endtask

    task automatic test_stop();
        bit same;
        sel = 1'b0;
        set_perm();
        set_text();
        build(32, 3, 0);
        load_ram();
        do_start(1'b0);
        watch(700, 41);
        n_chk++;
        if (aborted0 !== 1'b1 || failure0 !== 1'b0 || done_at != 43) begin
            n_fail++;
            $display("FAIL stop_wait: aborted %b failure %b done cycle %0d required 1 0 43",
                     aborted0, failure0, done_at);
        end
        n_chk++;
        if (bytes_done0 !== 6'd3 || n_mwr - mwr0 != 3 || n_swr - swr0 != 6) begin
            n_fail++;
            $display("FAIL stop_wait_counts: bytes %0d msg_wren %0d s_wren %0d required 3 3 6",
                     bytes_done0, n_mwr - mwr0, n_swr - swr0);
        end
        build(32, 1, 2);
        load_ram();
        do_start(1'b0);
        watch(700, 20);
        n_chk++;
        if (aborted0 !== 1'b1 || done_at != 24) begin
            n_fail++;
            $display("FAIL stop_wrj: aborted %b done cycle %0d required 1 24", aborted0, done_at);
        end
        n_chk++;
        if (bytes_done0 !== 6'd1 || n_swr - swr0 != 4) begin
            n_fail++;
            $display("FAIL stop_wrj_counts: bytes %0d s_wren %0d required 1 4", bytes_done0, n_swr - swr0);
        end
        same = 1'b1;
        for (int a = 0; a < 256; a++) if (smem[a] !== s_snap[a]) same = 1'b0;
        n_chk++;
        if (!same) begin
            n_fail++;
            $display("FAIL stop_wrj_swap: S RAM differs from model after two complete swaps");
        end
    endtask

    task automatic test_nocheck();
        sel = 1'b1;
        set_perm();
        for (int k = 0; k < 8; k++) pt[k] = 8'hFF;
        build(8, 8, 0);
        load_ram();
        do_start(1'b1);
        watch(300, 0);
        n_chk++;
        if (first_wr != 10 || done_at != 82) begin
            n_fail++;
            $display("FAIL nocheck_timing: first write %0d done %0d required 10 82", first_wr, done_at);
        end
        n_chk++;
        if ({success1, failure1, aborted1, busy1} !== 4'b1000 || bytes_done1 !== 4'd8) begin
            n_fail++;
            $display("FAIL nocheck_result: s/f/a/busy %b bytes %0d required 1000 8",
                     {success1, failure1, aborted1, busy1}, bytes_done1);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        set_perm();
        set_text();
        build(32, 0, 0);
        load_ram();
        do_start(1'b0);
        repeat (7) @(negedge clk);
        n_chk++;
        if (s_wren0 !== 1'b1 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: s_wren %b busy %b required 1 1", s_wren0, busy0);
        end
        #1 reset = 1'b0;
        #1;
        n_chk++;
        if (s_wren0 !== 1'b0 || busy0 !== 1'b0 || msg_wren0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: s_wren %b busy %b msg_wren %b required 0 0 0", s_wren0, busy0, msg_wren0);
        end
        @(negedge clk);
        reset = 1'b1;
        build(32, 32, 0);
        load_ram();
        do_start(1'b0);
        watch(700, 0);
        n_chk++;
        if (success0 !== 1'b1 || done_at != 418 || bytes_done0 !== 6'd32) begin
            n_fail++;
            $display("FAIL mid_rerun: success %b done cycle %0d bytes %0d required 1 418 32",
                     success0, done_at, bytes_done0);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_golden_pass();
        test_fail();
        test_stop();
        test_nocheck();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
